// File: rtl/xn2_target_update.sv
// xn2_target_update: builds the fixed-codebook target for one subframe,
//   xn2[i] = sub(xn[i], extract_h(L_shl(L_mult(y1[i], gain_pit), 1)))
// using saturating basic-op arithmetic. xn and y1 are read from the shared
// scratch memory (1-cycle read latency) and xn2 is written back to it.
// Each sample takes four states: RD_XN, RD_Y1, CALC, WR.
// Optional feature macro: SAT_OVF_EN adds a sticky 'overflow' output that
// flags any saturation in L_mult, L_shl or sub during the subframe.
module xn2_target_update #(
  parameter logic [11:0] XN_BASE  = 12'd0,
  parameter logic [11:0] Y1_BASE  = 12'd0,
  parameter logic [11:0] XN2_BASE = 12'd0,
  parameter int          L_SUBFR  = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] gain_pit,
  output logic        done,
  output logic [11:0] memReadAddr,
  input  logic [31:0] memIn,
  output logic [11:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn
`ifdef SAT_OVF_EN
  ,
  output logic        overflow
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_XN = 3'd1,
    RD_Y1 = 3'd2,
    CALC  = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [5:0] LAST_I = 6'(L_SUBFR - 1);

  state_t      state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [15:0] xn_q, xn_d;
  logic [15:0] xn2_q, xn2_d;
  logic        done_q, done_d;
`ifdef SAT_OVF_EN
  logic        ovf_q, ovf_d;
`endif

  // Arithmetic datapath signals (valid in CALC, when memIn carries y1)
  logic signed [31:0] prod;
  logic [31:0] p_mult;
  logic [31:0] q_shl;
  logic [15:0] t_hi;
  logic [16:0] diff;
  logic [15:0] xn2_calc;
  logic        lmult_sat;
  logic        shl_sat;
  logic        sub_sat;

  // Only the low half-word of a scratch word carries a sample.
  logic unused_mem_hi;
  assign unused_mem_hi = ^memIn[31:16];

  // Saturating L_mult -> L_shl(.,1) -> extract_h -> sub chain
  always_comb begin
    prod      = $signed(memIn[15:0]) * $signed(gain_pit);
    // The only L_mult overflow: (-1.0) * (-1.0)
    lmult_sat = (memIn[15:0] == 16'h8000) && (gain_pit == 16'h8000);
    p_mult    = lmult_sat ? 32'h7FFF_FFFF : {prod[30:0], 1'b0};
    // A left shift by one overflows whenever the top two bits differ
    shl_sat   = (p_mult[31] != p_mult[30]);
    q_shl     = shl_sat ? (p_mult[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                        : {p_mult[30:0], 1'b0};
    t_hi      = q_shl[31:16];
    diff      = {xn_q[15], xn_q} - {t_hi[15], t_hi};
    sub_sat   = (diff[16] != diff[15]);
    xn2_calc  = sub_sat ? (diff[16] ? 16'h8000 : 16'h7FFF) : diff[15:0];
  end

  // Next-state and register-update logic for the sample loop
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    xn_d    = xn_q;
    xn2_d   = xn2_q;
    done_d  = 1'b0;
`ifdef SAT_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          i_d     = 6'd0;
          state_d = RD_XN;
`ifdef SAT_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else if (state_q == DONE) begin
          done_d = 1'b1;
        end
      end
      RD_XN: state_d = RD_Y1;
      RD_Y1: begin
        xn_d    = memIn[15:0];
        state_d = CALC;
      end
      CALC: begin
        xn2_d   = xn2_calc;
        state_d = WR;
`ifdef SAT_OVF_EN
        ovf_d   = ovf_q | lmult_sat | shl_sat | sub_sat;
`endif
      end
      WR: begin
        i_d     = i_q + 6'd1;
        state_d = (i_q < LAST_I) ? RD_XN : DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= 6'd0;
      xn_q    <= 16'd0;
      xn2_q   <= 16'd0;
      done_q  <= 1'b0;
`ifdef SAT_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      xn_q    <= xn_d;
      xn2_q   <= xn2_d;
      done_q  <= done_d;
`ifdef SAT_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Memory-side outputs decoded from the current state; base and index are
  // concatenated so the index never carries into the base address.
  always_comb begin
    memReadAddr  = 12'd0;
    memWriteAddr = 12'd0;
    memOut       = 32'd0;
    case (state_q)
      RD_XN: memReadAddr = {XN_BASE[11:6], i_q};
      RD_Y1: memReadAddr = {Y1_BASE[11:6], i_q};
      WR: begin
        memWriteAddr = {XN2_BASE[11:6], i_q};
        memOut       = {{16{xn2_q[15]}}, xn2_q};
      end
      default: ;
    endcase
  end

  // Reset wins over a pending write so an aborted WR cycle never commits.
  assign memWriteEn = (state_q == WR) && reset;
  assign done       = done_q;
`ifdef SAT_OVF_EN
  assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_xn2_target_update.sv
// Testbench for xn2_target_update: directed vector table plus hand-written
// sequences for latency, mid-run start, mid-run reset and in-place runs.
module tb_xn2_target_update;

  localparam logic [11:0] XN_A  = 12'h100;
  localparam logic [11:0] Y1_A  = 12'h140;
  localparam logic [11:0] XN2_A = 12'h100;
  localparam int          NS    = 40;
  localparam longint      MAXL  = 64'sd2147483647;
  localparam longint      MINL  = -64'sd2147483648;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gain_pit = 16'd0;
  logic        done;
  logic [11:0] memReadAddr;
  logic [31:0] memIn;
  logic [11:0] memWriteAddr;
  logic [31:0] memOut;
  logic        memWriteEn;
`ifdef SAT_OVF_EN
  logic        overflow;
`endif

  always #5 clock = ~clock;

  xn2_target_update #(
    .XN_BASE (XN_A),
    .Y1_BASE (Y1_A),
    .XN2_BASE(XN2_A),
    .L_SUBFR (NS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .gain_pit    (gain_pit),
    .done        (done),
    .memReadAddr (memReadAddr),
    .memIn       (memIn),
    .memWriteAddr(memWriteAddr),
    .memOut      (memOut),
    .memWriteEn  (memWriteEn)
`ifdef SAT_OVF_EN
    ,
    .overflow    (overflow)
`endif
  );

  // Scratch memory: synchronous read, DUT write port plus a bench load port
  logic [31:0] mem [0:4095];
  logic [31:0] rdata = 32'd0;
  logic        tb_we = 1'b0;
  logic [11:0] tb_waddr = 12'd0;
  logic [31:0] tb_wdata = 32'd0;
  int          wr_count = 0;
  int          done_rises = 0;
  logic        done_prev = 1'b0;

  assign memIn = rdata;

  always @(posedge clock) begin
    rdata <= mem[memReadAddr];
    if (memWriteEn) begin
      mem[memWriteAddr] <= memOut;
      wr_count <= wr_count + 1;
    end else if (tb_we) begin
      mem[tb_waddr] <= tb_wdata;
    end
    done_prev <= done;
    if (done && !done_prev) done_rises <= done_rises + 1;
  end

  typedef struct {
    logic [15:0] xn;
    logic [15:0] y1;
    logic [15:0] g;
    logic [31:0] exp;
    logic        ovf;
  } vec_t;

  vec_t        tbl [8];
  logic [15:0] xn_v  [NS];
  logic [15:0] y1_v  [NS];
  logic [31:0] exp_v [NS];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference arithmetic written as plain integer basic ops
  function automatic logic [15:0] ref_xn2(input logic [15:0] xn, input logic [15:0] y1,
                                          input logic [15:0] g);
    longint a = longint'($signed(y1));
    longint b = longint'($signed(g));
    longint x = longint'($signed(xn));
    longint p, q, t, d;
    if (a == -32768 && b == -32768) p = MAXL;
    else p = a * b * 2;
    q = p * 2;
    if (q > MAXL) q = MAXL;
    if (q < MINL) q = MINL;
    t = q >>> 16;
    d = x - t;
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return d[15:0];
  endfunction

  task automatic load_mem();
    tb_we = 1'b1;
    for (int i = 0; i < NS; i++) begin
      tb_waddr = XN_A + 12'(i);
      tb_wdata = {{16{xn_v[i][15]}}, xn_v[i]};
      @(posedge clock); #1;
    end
    for (int i = 0; i < NS; i++) begin
      tb_waddr = Y1_A + 12'(i);
      tb_wdata = {{16{y1_v[i][15]}}, y1_v[i]};
      @(posedge clock); #1;
    end
    tb_we = 1'b0;
  endtask

  // Starts a subframe and returns the clocks from the start edge to done
  // (-1 on timeout); optionally pulses start again at clock pulse_at.
  task automatic run_sub(input logic [15:0] g, input int pulse_at, output int lat);
    gain_pit = g;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      if (n == pulse_at) start = 1'b1;
      else if (n == pulse_at + 1) start = 1'b0;
      @(posedge clock); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < NS; i++)
      check($sformatf("%s xn2[%0d]", tag, i), mem[XN2_A + 12'(i)], exp_v[i]);
  endtask

  initial begin
    int lat, w0, d0;
    // y1 * gain patterns with hand-computed xn2 (sign-extended)
    tbl[0] = '{16'h2000, 16'h1000, 16'h4000, 32'h0000_1000, 1'b0}; // nominal
    tbl[1] = '{16'h8000, 16'h7FFF, 16'h4CCD, 32'hFFFF_8000, 1'b1}; // L_shl + sub sat
    tbl[2] = '{16'h0000, 16'h8000, 16'h8000, 32'hFFFF_8001, 1'b1}; // L_mult sat
    tbl[3] = '{16'h7FFF, 16'h8000, 16'h4000, 32'h0000_7FFF, 1'b1}; // sub sat high
    tbl[4] = '{16'h0005, 16'h0001, 16'h2000, 32'h0000_0005, 1'b0}; // t truncates to 0
    tbl[5] = '{16'h0005, 16'hFFFF, 16'h2000, 32'h0000_0006, 1'b0}; // t floors to -1
    tbl[6] = '{16'h1234, 16'h5555, 16'h0000, 32'h0000_1234, 1'b0}; // zero gain
    tbl[7] = '{16'h0100, 16'h0400, 16'h3000, 32'hFFFF_FE00, 1'b0}; // negative result

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset done", {31'd0, done}, 32'd0);
    check("reset memWriteEn", {31'd0, memWriteEn}, 32'd0);
    check("reset memReadAddr", {20'd0, memReadAddr}, 32'd0);
    check("reset memWriteAddr", {20'd0, memWriteAddr}, 32'd0);
    check("reset memOut", memOut, 32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("idle no writes", 32'(wr_count), 32'd0);

    // Table-driven arithmetic vectors, in place
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < NS; i++) begin
        xn_v[i] = tbl[v].xn;
        y1_v[i] = tbl[v].y1;
        exp_v[i] = tbl[v].exp;
      end
      load_mem();
      w0 = wr_count;
      run_sub(tbl[v].g, -1, lat);
      check($sformatf("vec%0d latency", v), 32'(lat), 32'd161);
      check($sformatf("vec%0d writes", v), 32'(wr_count - w0), 32'(NS));
`ifdef SAT_OVF_EN
      check($sformatf("vec%0d overflow", v), {31'd0, overflow}, {31'd0, tbl[v].ovf});
`endif
      check_out($sformatf("vec%0d", v));
      $display("vector %0d: xn=%04h y1=%04h g=%04h latency=%0d", v, tbl[v].xn, tbl[v].y1, tbl[v].g, lat);
    end

    // done held while idle in DONE
    repeat (5) @(posedge clock);
    #1;
    check("done held", {31'd0, done}, 32'd1);

    // Zero gain, xn[i] = i-20
    for (int i = 0; i < NS; i++) begin
      xn_v[i] = 16'(i - 20);
      y1_v[i] = 16'(i * 997);
      exp_v[i] = {{16{xn_v[i][15]}}, xn_v[i]};
    end
    load_mem();
    run_sub(16'h0000, -1, lat);
    check("ramp latency", 32'(lat), 32'd161);
    check_out("ramp");
    check("ramp xn2[0]", mem[XN2_A], 32'hFFFF_FFEC);
    $display("ramp subframe: latency=%0d", lat);

    // Start pulsed mid-run is ignored
    for (int i = 0; i < NS; i++) begin
      xn_v[i] = tbl[0].xn;
      y1_v[i] = tbl[0].y1;
      exp_v[i] = tbl[0].exp;
    end
    load_mem();
    w0 = wr_count;
    d0 = done_rises;
    run_sub(16'h4000, 50, lat);
    @(posedge clock); #1;
    check("midstart latency", 32'(lat), 32'd161);
    check("midstart writes", 32'(wr_count - w0), 32'(NS));
    check("midstart done rises", 32'(done_rises - d0), 32'd1);
    check_out("midstart");
    $display("mid-run start subframe: latency=%0d writes=%0d", lat, wr_count - w0);

    // Reset during the WR cycle of sample 10
    for (int i = 0; i < NS; i++) begin
      xn_v[i] = 16'(16'h0300 + i);
      y1_v[i] = 16'h1000;
      exp_v[i] = {{16{ref_xn2(xn_v[i], y1_v[i], 16'h4000)}}, ref_xn2(xn_v[i], y1_v[i], 16'h4000)};
      exp_v[i] = {{16{exp_v[i][15]}}, exp_v[i][15:0]};
    end
    load_mem();
    w0 = wr_count;
    gain_pit = 16'h4000;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (43) @(posedge clock);
    #1;
    check("rst WR strobe", {31'd0, memWriteEn}, 32'd1);
    check("rst WR addr", {20'd0, memWriteAddr}, {20'd0, XN2_A + 12'd10});
    reset = 1'b0;
    #1;
    check("rst WE gated", {31'd0, memWriteEn}, 32'd0);
    @(posedge clock); #1;
    check("rst writes", 32'(wr_count - w0), 32'd10);
    check("rst sample10 kept", mem[XN2_A + 12'd10], {{16{xn_v[10][15]}}, xn_v[10]});
    check("rst sample9 written", mem[XN2_A + 12'd9], exp_v[9]);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst read addr", {20'd0, memReadAddr}, 32'd0);
    check("rst memOut", memOut, 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst stays idle", 32'(wr_count - w0), 32'd10);
    // Reload originals (samples 0..9 were overwritten) and redo all
    load_mem();
    w0 = wr_count;
    run_sub(16'h4000, -1, lat);
    check("rst rerun latency", 32'(lat), 32'd161);
    check("rst rerun writes", 32'(wr_count - w0), 32'(NS));
    check_out("rst rerun");
    $display("reset-abort subframe rerun: latency=%0d", lat);

    // Pseudo-random in-place subframes against the reference model
    for (int s = 0; s < 4; s++) begin
      logic [15:0] g;
      g = (s == 0) ? 16'h7FFF : 16'($urandom_range(0, 32767));
      for (int i = 0; i < NS; i++) begin
        xn_v[i] = 16'($urandom);
        y1_v[i] = (i == 3) ? 16'h8000 : 16'($urandom);
        exp_v[i] = {16'd0, ref_xn2(xn_v[i], y1_v[i], g)};
        exp_v[i] = {{16{exp_v[i][15]}}, exp_v[i][15:0]};
      end
      load_mem();
      run_sub(g, -1, lat);
      check($sformatf("rand%0d latency", s), 32'(lat), 32'd161);
      check_out($sformatf("rand%0d", s));
      $display("random subframe %0d: g=%04h latency=%0d", s, g, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
